// File: rtl/lenet_weight_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lenet_weight_loader
// Function : looks up a layer's weight/bias block, fetches it over a pipelined
//            read port and streams it word by word into the weight buffer
// Revision : 1.0  initial release
// ============================================================================
module lenet_weight_loader #(
  parameter int          DATA_W          = 32,
  parameter int          WBUF_AW         = 12,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [31:0] L1_BASE         = 32'h0001_0000,
  parameter int          L1_WORDS        = 156,
  parameter logic [31:0] L2_BASE         = 32'h0001_1000,
  parameter int          L2_WORDS        = 2416
) (
  input  logic               clk_i,
  input  logic               rst_async_n_i,
  input  logic               req_load_weight_i,
  input  logic [3:0]         layer_id_i,
  output logic               weight_loaded_o,
  output logic               err_bad_layer_o,
  output logic               busy_o,
  output logic               mem_req_o,
  output logic [31:0]        mem_addr_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic [DATA_W-1:0]  mem_rdata_i,
  output logic               wbuf_we_o,
  output logic [WBUF_AW-1:0] wbuf_addr_o,
  output logic [DATA_W-1:0]  wbuf_wdata_o
);

  localparam int c_cnt_w = WBUF_AW + 1;
  localparam int c_out_w = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_out_w-1:0] c_out_one = c_out_w'(1);
  localparam logic [c_out_w-1:0] c_max_out = c_out_w'(MAX_OUTSTANDING);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_fetch = 3'd1;
  localparam logic [2:0] c_st_abort = 3'd2;
  localparam logic [2:0] c_st_done  = 3'd3;
  localparam logic [2:0] c_st_err   = 3'd4;

  logic [2:0]          r_state;
  logic [2:0]          w_next_state;
  logic [31:0]         r_base;
  logic [c_cnt_w-1:0]  r_count;
  logic [c_cnt_w-1:0]  r_issued;
  logic [c_cnt_w-1:0]  r_received;
  logic [c_out_w-1:0]  r_outstanding;
  logic                r_we;
  logic [WBUF_AW-1:0]  r_waddr;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_valid_id;
  logic                w_mem_req;
  logic                w_gnt_fire;
  logic                w_rv_fire;
  logic                w_capture;
  logic                w_last_write;
  logic [31:0]         w_addr;

  assign w_valid_id = (layer_id_i == 4'd1) || (layer_id_i == 4'd2);
  assign w_mem_req  = (r_state == c_st_fetch) && (r_issued < r_count) &&
                      (r_outstanding < c_max_out);
  assign w_gnt_fire = w_mem_req && mem_gnt_i;
  // Returns with nothing in flight are stray and must not disturb the counters.
  assign w_rv_fire  = ((r_state == c_st_fetch) || (r_state == c_st_abort)) &&
                      mem_rvalid_i && (r_outstanding != '0);
  // Data returned in the cycle the request drops is counted but never written.
  assign w_capture  = w_rv_fire && (r_state == c_st_fetch) && req_load_weight_i;
  assign w_last_write = r_we && ({1'b0, r_waddr} == (r_count - c_cnt_one));
  assign w_addr     = r_base + (32'(r_issued) << 2);

  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (req_load_weight_i) begin
          w_next_state = w_valid_id ? c_st_fetch : c_st_err;
        end
      end
      c_st_fetch: begin
        if (!req_load_weight_i) begin
          w_next_state = c_st_abort;
        end else if (w_last_write) begin
          w_next_state = c_st_done;
        end
      end
      c_st_abort: begin
        if ((r_outstanding == '0) || ((r_outstanding == c_out_one) && w_rv_fire)) begin
          w_next_state = c_st_idle;
        end
      end
      c_st_done, c_st_err: begin
        if (!req_load_weight_i) begin
          w_next_state = c_st_idle;
        end
      end
      default: w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    busy_o          = 1'b0;
    weight_loaded_o = 1'b0;
    err_bad_layer_o = 1'b0;
    mem_req_o       = 1'b0;
    mem_addr_o      = '0;
    case (r_state)
      c_st_fetch: begin
        busy_o     = 1'b1;
        mem_req_o  = w_mem_req;
        mem_addr_o = w_mem_req ? w_addr : '0;
      end
      c_st_abort: begin
        busy_o = 1'b1;
      end
      c_st_done: begin
        busy_o          = 1'b1;
        weight_loaded_o = 1'b1;
      end
      c_st_err: begin
        busy_o          = 1'b1;
        weight_loaded_o = 1'b1;
        err_bad_layer_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      r_base        <= '0;
      r_count       <= '0;
      r_issued      <= '0;
      r_received    <= '0;
      r_outstanding <= '0;
      r_we          <= 1'b0;
      r_waddr       <= '0;
      r_wdata       <= '0;
    end else begin
      if (r_state == c_st_idle) begin
        r_issued      <= '0;
        r_received    <= '0;
        r_outstanding <= '0;
        if (req_load_weight_i && (layer_id_i == 4'd1)) begin
          r_base  <= L1_BASE;
          r_count <= c_cnt_w'(L1_WORDS);
        end else if (req_load_weight_i && (layer_id_i == 4'd2)) begin
          r_base  <= L2_BASE;
          r_count <= c_cnt_w'(L2_WORDS);
        end
      end else begin
        if (w_gnt_fire) begin
          r_issued <= r_issued + c_cnt_one;
        end
        if (w_rv_fire) begin
          r_received <= r_received + c_cnt_one;
        end
        if (w_gnt_fire && !w_rv_fire) begin
          r_outstanding <= r_outstanding + c_out_one;
        end else if (!w_gnt_fire && w_rv_fire) begin
          r_outstanding <= r_outstanding - c_out_one;
        end
      end
      r_we <= w_capture;
      if (w_capture) begin
        r_waddr <= r_received[WBUF_AW-1:0];
        r_wdata <= mem_rdata_i;
      end
    end
  end

  assign wbuf_we_o    = r_we;
  assign wbuf_addr_o  = r_waddr;
  assign wbuf_wdata_o = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lenet_weight_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lenet_weight_loader
// Function : table-driven load scenarios against a memory/buffer model plus
//            directed abort, reset and stray-return sequences
// Revision : 1.0  initial release
// ============================================================================
module tb_lenet_weight_loader;

  localparam int          DATA_W  = 32;
  localparam int          WBUF_AW = 12;
  localparam int          MAX_OUT = 4;
  localparam logic [31:0] L1_BASE = 32'h0001_0000;
  localparam logic [31:0] L2_BASE = 32'h0001_1000;

  logic               clk_i = 1'b0;
  logic               rst_async_n_i;
  logic               req_load_weight_i;
  logic [3:0]         layer_id_i;
  logic               weight_loaded_o;
  logic               err_bad_layer_o;
  logic               busy_o;
  logic               mem_req_o;
  logic [31:0]        mem_addr_o;
  logic               mem_gnt_i;
  logic               mem_rvalid_i;
  logic [DATA_W-1:0]  mem_rdata_i;
  logic               wbuf_we_o;
  logic [WBUF_AW-1:0] wbuf_addr_o;
  logic [DATA_W-1:0]  wbuf_wdata_o;

  lenet_weight_loader dut (
    .clk_i             (clk_i),
    .rst_async_n_i     (rst_async_n_i),
    .req_load_weight_i (req_load_weight_i),
    .layer_id_i        (layer_id_i),
    .weight_loaded_o   (weight_loaded_o),
    .err_bad_layer_o   (err_bad_layer_o),
    .busy_o            (busy_o),
    .mem_req_o         (mem_req_o),
    .mem_addr_o        (mem_addr_o),
    .mem_gnt_i         (mem_gnt_i),
    .mem_rvalid_i      (mem_rvalid_i),
    .mem_rdata_i       (mem_rdata_i),
    .wbuf_we_o         (wbuf_we_o),
    .wbuf_addr_o       (wbuf_addr_o),
    .wbuf_wdata_o      (wbuf_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] id;
    int         gnt_pct;
    int         lat_min;
    int         lat_max;
    bit         rand_key;
    bit         exp_err;
    int         exp_words;
    bit         no_bubble;
  } vec_t;

  typedef struct {
    int          ready;
    logic [31:0] data;
  } rd_t;

  vec_t        vecs[6];
  rd_t         q[$];
  rd_t         e;

  int n_pass = 0;
  int n_total = 0;

  // Memory model configuration and observation state
  int          cyc = 0;
  int          gnt_pct, lat_min, lat_max, grant_limit, ret_limit, exp_words;
  logic [31:0] key, exp_base, first_addr, last_addr, prev_addr;
  int          grant_cnt, ret_cnt, wr_cnt, wr_err, addr_err, stall_err;
  int          req_seen, max_out, bubbles, loaded_cyc, last_ret_cyc, stray_seen, pend;
  bit          inject_stray = 1'b0;
  bit          prev_req, prev_gnt;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk_i);
    #2;
  endtask

  task automatic start_cfg(input logic [31:0] base, input int words, input int pct,
                           input int lmin, input int lmax, input bit rkey);
    exp_base = base;  exp_words = words;  gnt_pct = pct;
    lat_min = lmin;   lat_max = lmax;
    key = rkey ? $urandom : 32'h0;
    grant_limit = 1 << 30;  ret_limit = 1 << 30;
    grant_cnt = 0;  ret_cnt = 0;  wr_cnt = 0;  wr_err = 0;  addr_err = 0;
    stall_err = 0;  req_seen = 0; max_out = 0; bubbles = 0; stray_seen = 0;
    loaded_cyc = -1; last_ret_cyc = -1;
  endtask

  // Memory: word k of the block holds k ^ key; returns in order after 1+ cycles.
  initial begin
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    prev_req = 1'b0;  prev_gnt = 1'b0;     prev_addr = '0;
    forever begin
      @(negedge clk_i);
      #1;
      cyc++;
      if (!rst_async_n_i) begin
        q.delete();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        prev_req = 1'b0;  prev_gnt = 1'b0;
      end else begin
        pend = grant_cnt - ret_cnt;
        if (pend > max_out) max_out = pend;
        if (wbuf_we_o) begin
          if (wbuf_addr_o != WBUF_AW'(wr_cnt) || wbuf_wdata_o != (32'(wr_cnt) ^ key)) wr_err++;
          wr_cnt++;
        end
        if (mem_req_o) req_seen++;
        if (weight_loaded_o && loaded_cyc < 0) loaded_cyc = cyc;
        if (prev_req && !prev_gnt && req_load_weight_i &&
            (!mem_req_o || mem_addr_o != prev_addr)) stall_err++;
        if (!mem_req_o && busy_o && !weight_loaded_o && req_load_weight_i &&
            grant_cnt > 0 && grant_cnt < exp_words) bubbles++;

        mem_gnt_i = mem_req_o && (grant_cnt < grant_limit) &&
                    (int'($urandom_range(99)) < gnt_pct);
        if (mem_gnt_i) begin
          if (mem_addr_o != exp_base + 32'(grant_cnt) * 32'd4) addr_err++;
          if (grant_cnt == 0) first_addr = mem_addr_o;
          last_addr = mem_addr_o;
          e.ready = cyc + int'($urandom_range(lat_max, lat_min));
          e.data  = ((mem_addr_o - exp_base) >> 2) ^ key;
          q.push_back(e);
          grant_cnt++;
        end

        if (inject_stray && q.size() == 0) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; inject_stray = 1'b0;
        end else if (q.size() > 0 && q[0].ready <= cyc && ret_cnt < ret_limit) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = q[0].data;
          void'(q.pop_front());
          ret_cnt++; last_ret_cyc = cyc;
        end else begin
          mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
        end
        // Protocol monitor: a return with nothing in flight is a slave error.
        if (mem_rvalid_i && pend == 0) begin
          stray_seen++;
          $display("protocol: rvalid with no read outstanding at cycle %0d", cyc);
        end
        prev_req = mem_req_o; prev_gnt = mem_gnt_i; prev_addr = mem_addr_o;
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int n;
    int rs;
    int drops;
    logic [31:0] base;
    base = (v.id == 4'd2) ? L2_BASE : L1_BASE;
    start_cfg(base, v.exp_words, v.gnt_pct, v.lat_min, v.lat_max, v.rand_key);
    layer_id_i = v.id;
    req_load_weight_i = 1'b1;
    tick();
    if (v.exp_err) begin
      check("err_flag", err_bad_layer_o, 1);
      check("err_loaded", weight_loaded_o, 1);
      repeat (4) tick();
      check("err_no_traffic", req_seen + wr_cnt, 0);
      req_load_weight_i = 1'b0;
      tick();
      check("err_clear", {err_bad_layer_o, weight_loaded_o, busy_o}, 0);
    end else begin
      n = 0;
      while (!weight_loaded_o && n < 20000) begin
        tick();
        n++;
      end
      check("load_complete", weight_loaded_o, 1);
      check("load_no_err", err_bad_layer_o, 0);
      check("loaded_2_after_last_rvalid", loaded_cyc - last_ret_cyc, 2);
      check("addr_sequence_errs", addr_err, 0);
      check("addr_stall_errs", stall_err, 0);
      check("outstanding_le_max", max_out <= MAX_OUT, 1);
      check("first_addr", first_addr, base);
      check("last_addr", last_addr, base + 32'(v.exp_words - 1) * 32'd4);
      if (v.no_bubble) check("req_bubbles", bubbles, 0);
      rs = req_seen;
      drops = 0;
      repeat (10) begin
        tick();
        if (!weight_loaded_o) drops++;
      end
      check("done_hold_loaded", drops, 0);
      check("done_no_refetch", req_seen - rs, 0);
      check("write_count", wr_cnt, v.exp_words);
      check("write_data_errs", wr_err, 0);
      req_load_weight_i = 1'b0;
      tick();
      check("idle_after_drop", {busy_o, weight_loaded_o}, 0);
    end
    tick();
  endtask

  initial begin
    int n;
    vecs[0] = '{4'd1,  100, 2, 2, 1'b0, 1'b0, 156,  1'b1};
    vecs[1] = '{4'd2,   60, 1, 6, 1'b1, 1'b0, 2416, 1'b0};
    vecs[2] = '{4'd3,  100, 1, 1, 1'b0, 1'b1, 0,    1'b0};
    vecs[3] = '{4'd0,  100, 1, 1, 1'b0, 1'b1, 0,    1'b0};
    vecs[4] = '{4'd15, 100, 1, 1, 1'b0, 1'b1, 0,    1'b0};
    vecs[5] = '{4'd1,   50, 1, 6, 1'b1, 1'b0, 156,  1'b0};

    start_cfg(L1_BASE, 156, 100, 1, 1, 1'b0);
    rst_async_n_i = 1'b0;
    req_load_weight_i = 1'b0;
    layer_id_i = 4'd0;
    repeat (3) tick();
    check("reset_ctrl_outputs",
          {weight_loaded_o, err_bad_layer_o, busy_o, mem_req_o, wbuf_we_o}, 0);
    check("reset_mem_addr", mem_addr_o, 0);
    check("reset_wbuf_addr_data", {wbuf_addr_o, wbuf_wdata_o}, 0);
    rst_async_n_i = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Stray return while nothing is outstanding must be ignored.
    start_cfg(L1_BASE, 156, 0, 1, 3, 1'b1);
    layer_id_i = 4'd1;
    req_load_weight_i = 1'b1;
    repeat (2) tick();
    inject_stray = 1'b1;
    repeat (3) tick();
    check("stray_no_write", wr_cnt, 0);
    check("stray_flagged", stray_seen, 1);
    gnt_pct = 100;
    n = 0;
    while (!weight_loaded_o && n < 5000) begin
      tick();
      n++;
    end
    check("stray_load_complete", weight_loaded_o, 1);
    check("stray_write_count", wr_cnt, 156);
    check("stray_write_data_errs", wr_err, 0);
    req_load_weight_i = 1'b0;
    repeat (2) tick();

    // Abort with three reads in flight after forty grants.
    start_cfg(L1_BASE, 156, 100, 2, 2, 1'b1);
    grant_limit = 40;
    ret_limit = 37;
    layer_id_i = 4'd1;
    req_load_weight_i = 1'b1;
    n = 0;
    while (!(grant_cnt == 40 && ret_cnt == 37) && n < 500) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check("abort_pre_writes", wr_cnt, 37);
    check("abort_pre_req_pending", mem_req_o, 1);
    req_load_weight_i = 1'b0;
    tick();
    check("abort_req_drop", mem_req_o, 0);
    ret_limit = 40;
    n = 0;
    while (ret_cnt < 40 && n < 50) begin
      tick();
      n++;
    end
    check("abort_all_returned", ret_cnt, 40);
    check("abort_busy_before_last", busy_o, 1);
    tick();
    check("abort_busy_fall", busy_o, 0);
    tick();
    check("abort_no_late_writes", wr_cnt, 37);
    check("abort_not_loaded", weight_loaded_o, 0);
    tick();
    run_vec(vecs[0]);

    // Asynchronous reset in the middle of a fetch.
    start_cfg(L1_BASE, 156, 100, 2, 3, 1'b1);
    layer_id_i = 4'd1;
    req_load_weight_i = 1'b1;
    n = 0;
    while (wr_cnt < 30 && n < 500) begin
      tick();
      n++;
    end
    check("rst_mid_progress", wr_cnt >= 30, 1);
    rst_async_n_i = 1'b0;
    #1;
    check("rst_mid_ctrl_outputs",
          {weight_loaded_o, err_bad_layer_o, busy_o, mem_req_o, wbuf_we_o}, 0);
    check("rst_mid_mem_addr", mem_addr_o, 0);
    tick();
    req_load_weight_i = 1'b0;
    tick();
    rst_async_n_i = 1'b1;
    tick();
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/lenet_weight_loader.md
Name: lenet_weight_loader

Overview:
- Services the layer controller's weight-load handshake (request plus 4-bit layer ID; acknowledged by a weight-loaded level).
- On each request, looks up the layer's weight/bias block in an internal descriptor table and fetches it word by word over a pipelined read interface with grant and in-order data return.
- Writes each word sequentially into the systolic core's weight buffer.
- Bounds outstanding reads, handles aborts and flags unknown layer IDs.

Parameters:
- DATA_W, 32, width of the memory read data and of the weight-buffer write data.
- WBUF_AW, 12, weight-buffer word-address width.
- MAX_OUTSTANDING, 4, maximum number of granted but unreturned reads (range 1..15).
- L1_BASE, 32'h0001_0000, byte base address of the layer-1 block (6x1x25 weights + 6 biases).
- L1_WORDS, 156, word count for layer 1.
- L2_BASE, 32'h0001_1000, byte base address of the layer-2 block (16x6x25 weights + 16 biases).
- L2_WORDS, 2416, word count for layer 2 (must be <= 2**WBUF_AW).

Ports:
- clk_i  in  1  clock
- rst_async_n_i  in  1  reset, asynchronous, active-low
- req_load_weight_i  in  1  load request level from the layer controller
- layer_id_i  in  4  layer to load; sampled in IDLE when the request rises
- weight_loaded_o  out  1  load-complete level returned to the controller
- err_bad_layer_o  out  1  unknown layer ID for the current request
- busy_o  out  1  high in any state other than IDLE
- mem_req_o  out  1  read request
- mem_addr_o  out  32  read byte address
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid (in order, at least 1 cycle after grant)
- mem_rdata_i  in  DATA_W  read data
- wbuf_we_o  out  1  weight-buffer write enable
- wbuf_addr_o  out  WBUF_AW  weight-buffer word address
- wbuf_wdata_o  out  DATA_W  weight-buffer write data

Behaviour:
- Reset values: all outputs 0; state IDLE; counters issued, received and outstanding all 0. Reset mid-load drops everything immediately with no further writes.
- IDLE:
  - On req_load_weight_i=1, latch layer_id_i.
  - ID 1 loads base/count from L1_BASE/L1_WORDS; ID 2 loads L2_BASE/L2_WORDS; go to FETCH.
  - Any other ID goes to ERR.
  - mem_rvalid_i in IDLE is ignored.
- FETCH:
  - mem_req_o = (issued < count) && (outstanding < MAX_OUTSTANDING).
  - mem_addr_o = base + 4*issued; held stable while mem_req_o=1 and not granted.
  - mem_req_o & mem_gnt_i: issued+1.
  - mem_rvalid_i: received+1; next cycle wbuf_we_o=1, wbuf_addr_o = received (pre-increment value), wbuf_wdata_o = captured mem_rdata_i. Write latency is exactly 1 cycle.
  - outstanding = issued - received; grant and rvalid in the same cycle leaves it unchanged.
  - When the write of word count-1 is on wbuf_we_o, next state is DONE. Last rvalid at cycle t gives the write at t+1 and weight_loaded_o at t+2.
  - req_load_weight_i=0 during FETCH goes to ABORT.
- ABORT:
  - mem_req_o=0; no buffer writes.
  - Absorb rvalids until outstanding=0, then IDLE.
  - weight_loaded_o stays 0.
- DONE:
  - weight_loaded_o=1.
  - Return to IDLE when req_load_weight_i=0. A held request does not restart the load.
- ERR:
  - err_bad_layer_o=1 and weight_loaded_o=1 so the controller's handshake completes; zero words fetched or written.
  - Return to IDLE when req_load_weight_i=0; both outputs clear in that cycle.
- Counters are WBUF_AW+1 bits wide; the outstanding counter is $clog2(MAX_OUTSTANDING+1) bits. No wrap-around occurs because count <= 2**WBUF_AW.
- Back-to-back loads (layer 1 then layer 2): each request starts from zero counters, and the buffer address restarts at 0.
- mem_rvalid_i with outstanding=0 in FETCH is a protocol error: ignore it, do not write, and flag it with a bench assertion.

Test Plan:
- Layer-1 load, mem_gnt_i always 1, 2-cycle read latency, rdata = index -> exactly 156 writes with addr=data=0..155 in order; weight_loaded_o high 2 cycles after the last rvalid; first mem_addr_o=0x0001_0000, last 0x0001_026C.
- Layer-2 load with random grant stalls and 1..6-cycle latency -> 2416 sequential writes; outstanding never exceeds 4; mem_addr_o stable during every stall; no write gaps reorder data.
- layer_id_i=3 -> err_bad_layer_o=1 and weight_loaded_o=1 next cycle; no mem_req_o or wbuf_we_o; both clear when the request drops.
- Request dropped after 40 grants with 3 outstanding -> mem_req_o=0 the next cycle; 3 late rvalids produce no writes; busy_o falls after the third; a following layer-1 load writes from addr 0.
- Async reset asserted mid-FETCH -> all outputs 0 immediately; after release, a full layer-1 load completes correctly.
- Request held high after DONE for 10 cycles -> weight_loaded_o stays 1, no refetch; grant and rvalid coincident every cycle keeps outstanding constant.
